lockin_demod: RTL and testbench
===============================

# lockin_demod

Synchronous I/Q lock-in demodulator: the receive end of the excitation path driven by `sine_lut`. It multiplies each incoming ADC/decimator sample by the `o_sin`/`o_cos` reference that `sine_lut` produces for the same phase. It integrates both products over a whole number of reference periods, delimited by phase-accumulator wraps. It then presents one in-phase/quadrature result pair per measurement, which the readout controller uses to compute sensor amplitude and phase.

## Interface
- `S_WIDTH`, default 12: signed input sample width.
- `REF_WIDTH`, default 12: signed reference width; matches `sine_lut` `O_WIDTH`.
- `PHASE_WIDTH`, default 13: phase word width; matches `sine_lut` `I_WIDTH`.
- `ACC_WIDTH`, default 32: signed accumulator and result width; must be ≥ `S_WIDTH+REF_WIDTH`.
- `N_WIDTH`, default 8: width of the period-count input.
- `i_clk`, input, 1: system clock. The block has a single clock domain.
- `i_rst`, input, 1: reset, asynchronous and active-low.
- `i_en`, input, 1: clock enable. While low, all state, pipeline registers and outputs hold.
- `i_start`, input, 1: single-cycle request to begin a measurement.
- `i_n_periods`, input, `N_WIDTH`: number of reference periods to integrate. Captured on an accepted `i_start`.
- `i_sample_valid`, input, 1: qualifies `i_sample`, `i_sin`, `i_cos` and `i_phase`.
- `i_sample`, input, signed `S_WIDTH`: measured signal.
- `i_sin`, input, signed `REF_WIDTH`: sine reference, phase-aligned with `i_sample`.
- `i_cos`, input, signed `REF_WIDTH`: cosine reference, phase-aligned with `i_sample`.
- `i_phase`, input, `PHASE_WIDTH`: reference phase for the current sample.
- `o_i`, output, signed `ACC_WIDTH`: in-phase result, Σ sample·sin.
- `o_q`, output, signed `ACC_WIDTH`: quadrature result, Σ sample·cos.
- `o_valid`, output, 1: one-cycle strobe marking a new `o_i`/`o_q`.
- `o_busy`, output, 1: high in every state except IDLE.
- `o_ovf`, output, 1: accumulator overflow occurred during the last measurement. Updated together with `o_valid`.

## Operation
- Wrap event, `wrap`: `i_sample_valid` high, and the `i_phase` MSB is 0 while the MSB of the previous valid sample was 1.
  - The previous-MSB register updates on every valid sample in all states. It resets to 0.
- States:
  - IDLE → ARM on `i_start`. Captures `i_n_periods`; a value of 0 is treated as 1. `i_start` in any other state is ignored.
  - ARM → ACC on `wrap`. The wrapping sample is the first sample accumulated, and its tag is `first`.
  - ACC: every valid sample is accumulated. The period counter decrements on each `wrap`.
    - When a `wrap` arrives with the counter at 1, go to DONE. That wrapping sample is not accumulated.
  - DONE: lasts 2 enabled cycles to drain the pipeline, then returns to IDLE.
- Pipeline:
  - Stage 1 registers full-width products `i_sample*i_sin` and `i_sample*i_cos` (`S_WIDTH+REF_WIDTH` bits) plus the tags `acc_en` and `first`.
  - Stage 2: on `acc_en`, the accumulator loads the product if `first` is set, otherwise adds the product sign-extended to `ACC_WIDTH`.
- Overflow: detected from the operand and result signs. The sticky flag clears on `first`.
- Results:
  - On exit from DONE, the accumulators are copied to `o_i`/`o_q` and the sticky flag to `o_ovf`, and `o_valid` pulses.
  - Outputs hold until the next result.
- Reset values: every output 0, state IDLE, accumulators and pipeline registers 0.
- Reset asserted mid-measurement aborts the measurement. No `o_valid` is issued.

## Timing
- Let E be the enabled edge that samples the terminating `wrap`.
  - At E: state becomes DONE.
  - At E+1: the last accumulate has completed.
  - At E+2: outputs load and state becomes IDLE.
  - `o_valid` is high for exactly the one enabled cycle after E+2.
- Cycles with `i_en` low are not counted; they stretch all latencies.
- First accumulated sample: the product registers at +1 edge and the accumulator at +2 edges.
- `o_busy` rises the cycle after the accepted `i_start` and falls at the E+2 edge.
- A new `i_start` may be accepted in the same cycle that `o_valid` is high.
- Samples with `i_sample_valid` low are ignored. Irregular sample spacing is legal.

## Configuration
- `LOCKIN_DEMOD_SATURATE_EN` defined: on overflow, each accumulator clamps to +2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1). Once clamped, it stays clamped for the rest of that measurement.
- Not defined: the accumulators wrap modulo 2^ACC_WIDTH.
- `o_ovf` is reported in both builds.

## Test plan
All scenarios use default parameters, with `i_phase` incrementing by 1 per valid sample.
- Basic I: `i_sample`=100, `i_sin`=2047, `i_cos`=0, N=1 → `o_i`=1676902400, `o_q`=0, `o_ovf`=0, one `o_valid` pulse.
- Saturation: same as Basic I with N=2.
  - With the macro: `o_i`=2147483647, `o_ovf`=1.
  - Without the macro: `o_i`=-941162496, `o_ovf`=1.
- Quadrature sign: `i_sample`=-5, `i_sin`=0, `i_cos`=1000, N=3 → `o_i`=0, `o_q`=-122880000.
- Alignment: assert `i_start` when `i_phase`=4000 → no accumulation until phase 0. `o_valid` occurs exactly 2 enabled cycles after the edge sampling the 2nd wrap (N=1 case).
- Stall and ignore:
  - Hold `i_en` low for 10 cycles mid-ACC → identical results, latency stretched by 10.
  - `i_start` pulsed during ACC → ignored, no extra `o_valid`.
- Reset mid-ACC: assert `i_rst` low → all outputs 0 asynchronously. After release, `o_busy`=0 and no `o_valid` is issued.

Source files
------------

// File: rtl/lockin_demod.sv
// Synchronous I/Q lock-in demodulator: integrates sample*sin and sample*cos over N reference periods.
// Optional build macro LOCKIN_DEMOD_SATURATE_EN clamps the accumulators on overflow instead of wrapping.
module lockin_demod #(
  parameter int S_WIDTH     = 12,
  parameter int REF_WIDTH   = 12,
  parameter int PHASE_WIDTH = 13,
  parameter int ACC_WIDTH   = 32,
  parameter int N_WIDTH     = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_en,
  input  logic                        i_start,
  input  logic [N_WIDTH-1:0]          i_n_periods,
  input  logic                        i_sample_valid,
  input  logic signed [S_WIDTH-1:0]   i_sample,
  input  logic signed [REF_WIDTH-1:0] i_sin,
  input  logic signed [REF_WIDTH-1:0] i_cos,
  input  logic [PHASE_WIDTH-1:0]      i_phase,
  output logic signed [ACC_WIDTH-1:0] o_i,
  output logic signed [ACC_WIDTH-1:0] o_q,
  output logic                        o_valid,
  output logic                        o_busy,
  output logic                        o_ovf
);

  localparam int P_WIDTH = S_WIDTH + REF_WIDTH;

  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_ACC, ST_DONE} state_t;

  typedef struct packed {
    logic                        sat;
    logic                        ovf;
    logic signed [ACC_WIDTH-1:0] val;
  } acc_res_t;

  // One accumulate step: signed add with overflow from operand/result signs.
  function automatic acc_res_t acc_step(input logic signed [ACC_WIDTH-1:0] acc,
                                        input logic signed [ACC_WIDTH-1:0] addend,
                                        input logic                        sat);
    acc_res_t                    res;
    logic signed [ACC_WIDTH-1:0] sum;
    sum     = acc + addend;
    res.ovf = (acc[ACC_WIDTH-1] == addend[ACC_WIDTH-1]) &&
              (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
    res.sat = sat | res.ovf;
`ifdef LOCKIN_DEMOD_SATURATE_EN
    if (sat)
      res.val = acc;
    else if (res.ovf)
      res.val = acc[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                 : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    else
      res.val = sum;
`else
    res.val = sum;
`endif
    return res;
  endfunction

  state_t                      state_q, state_d;
  logic [N_WIDTH-1:0]          n_cnt_q, n_cnt_d;
  logic                        done_cnt_q, done_cnt_d;
  logic                        prev_msb_q, prev_msb_d;
  logic signed [P_WIDTH-1:0]   prod_inph_q, prod_inph_d;
  logic signed [P_WIDTH-1:0]   prod_quad_q, prod_quad_d;
  logic                        acc_en_q, acc_en_d;
  logic                        first_q, first_d;
  logic signed [ACC_WIDTH-1:0] acc_inph_q, acc_inph_d;
  logic signed [ACC_WIDTH-1:0] acc_quad_q, acc_quad_d;
  logic                        sat_inph_q, sat_inph_d;
  logic                        sat_quad_q, sat_quad_d;
  logic                        ovf_q, ovf_d;
  logic signed [ACC_WIDTH-1:0] o_i_q, o_i_d;
  logic signed [ACC_WIDTH-1:0] o_q_q, o_q_d;
  logic                        o_valid_q, o_valid_d;
  logic                        o_ovf_q, o_ovf_d;

  logic                        wrap;
  logic                        load_out;
  logic signed [ACC_WIDTH-1:0] ext_inph, ext_quad;
  acc_res_t                    res_inph, res_quad;
  logic                        unused_phase_bits;

  // Only the phase MSB is needed to spot the period boundary.
  assign unused_phase_bits = ^i_phase[PHASE_WIDTH-2:0];
  assign wrap = i_sample_valid && !i_phase[PHASE_WIDTH-1] && prev_msb_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    n_cnt_d    = n_cnt_q;
    done_cnt_d = done_cnt_q;
    acc_en_d   = 1'b0;
    first_d    = 1'b0;
    load_out   = 1'b0;
    prev_msb_d = i_sample_valid ? i_phase[PHASE_WIDTH-1] : prev_msb_q;

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_ARM;
          n_cnt_d = (i_n_periods == '0) ? N_WIDTH'(1) : i_n_periods;
        end
      end
      ST_ARM: begin
        if (wrap) begin
          state_d  = ST_ACC;
          acc_en_d = 1'b1;
          first_d  = 1'b1;
        end
      end
      ST_ACC: begin
        if (wrap && n_cnt_q == N_WIDTH'(1)) begin
          state_d    = ST_DONE;
          done_cnt_d = 1'b0;
        end else begin
          acc_en_d = i_sample_valid;
          if (wrap) n_cnt_d = n_cnt_q - N_WIDTH'(1);
        end
      end
      ST_DONE: begin
        if (done_cnt_q) begin
          state_d  = ST_IDLE;
          load_out = 1'b1;
        end else begin
          done_cnt_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    prod_inph_d = i_sample * i_sin;
    prod_quad_d = i_sample * i_cos;
    ext_inph    = ACC_WIDTH'(prod_inph_q);
    ext_quad    = ACC_WIDTH'(prod_quad_q);
    res_inph    = acc_step(acc_inph_q, ext_inph, sat_inph_q);
    res_quad    = acc_step(acc_quad_q, ext_quad, sat_quad_q);

    acc_inph_d = acc_inph_q;
    acc_quad_d = acc_quad_q;
    sat_inph_d = sat_inph_q;
    sat_quad_d = sat_quad_q;
    ovf_d      = ovf_q;
    if (acc_en_q) begin
      if (first_q) begin
        acc_inph_d = ext_inph;
        acc_quad_d = ext_quad;
        sat_inph_d = 1'b0;
        sat_quad_d = 1'b0;
        ovf_d      = 1'b0;
      end else begin
        acc_inph_d = res_inph.val;
        acc_quad_d = res_quad.val;
        sat_inph_d = res_inph.sat;
        sat_quad_d = res_quad.sat;
        ovf_d      = ovf_q | res_inph.ovf | res_quad.ovf;
      end
    end

    o_valid_d = load_out;
    o_i_d     = load_out ? acc_inph_q : o_i_q;
    o_q_d     = load_out ? acc_quad_q : o_q_q;
    o_ovf_d   = load_out ? ovf_q      : o_ovf_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= ST_IDLE;
      n_cnt_q     <= '0;
      done_cnt_q  <= 1'b0;
      prev_msb_q  <= 1'b0;
      prod_inph_q <= '0;
      prod_quad_q <= '0;
      acc_en_q    <= 1'b0;
      first_q     <= 1'b0;
      acc_inph_q  <= '0;
      acc_quad_q  <= '0;
      sat_inph_q  <= 1'b0;
      sat_quad_q  <= 1'b0;
      ovf_q       <= 1'b0;
      o_i_q       <= '0;
      o_q_q       <= '0;
      o_valid_q   <= 1'b0;
      o_ovf_q     <= 1'b0;
    end else if (i_en) begin
      state_q     <= state_d;
      n_cnt_q     <= n_cnt_d;
      done_cnt_q  <= done_cnt_d;
      prev_msb_q  <= prev_msb_d;
      prod_inph_q <= prod_inph_d;
      prod_quad_q <= prod_quad_d;
      acc_en_q    <= acc_en_d;
      first_q     <= first_d;
      acc_inph_q  <= acc_inph_d;
      acc_quad_q  <= acc_quad_d;
      sat_inph_q  <= sat_inph_d;
      sat_quad_q  <= sat_quad_d;
      ovf_q       <= ovf_d;
      o_i_q       <= o_i_d;
      o_q_q       <= o_q_d;
      o_valid_q   <= o_valid_d;
      o_ovf_q     <= o_ovf_d;
    end
  end

  assign o_i     = o_i_q;
  assign o_q     = o_q_q;
  assign o_valid = o_valid_q;
  assign o_ovf   = o_ovf_q;
  assign o_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lockin_demod.sv
// Directed bench for lockin_demod: constant-product measurements with hand-computed sums and latencies.
module tb_lockin_demod;

  localparam int S_WIDTH     = 12;
  localparam int REF_WIDTH   = 12;
  localparam int PHASE_WIDTH = 13;
  localparam int ACC_WIDTH   = 32;
  localparam int N_WIDTH     = 8;

  logic                        i_clk = 1'b0;
  logic                        i_rst = 1'b0;
  logic                        i_en = 1'b0;
  logic                        i_start = 1'b0;
  logic [N_WIDTH-1:0]          i_n_periods = '0;
  logic                        i_sample_valid = 1'b0;
  logic signed [S_WIDTH-1:0]   i_sample = '0;
  logic signed [REF_WIDTH-1:0] i_sin = '0;
  logic signed [REF_WIDTH-1:0] i_cos = '0;
  logic [PHASE_WIDTH-1:0]      i_phase = '0;
  logic signed [ACC_WIDTH-1:0] o_i, o_q;
  logic                        o_valid, o_busy, o_ovf;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int valid_cyc = 0;
  int last_wrap_cyc = 0;
  int lat;
  logic signed [ACC_WIDTH-1:0] cap_i, cap_q;
  logic cap_ovf;

  lockin_demod #(
    .S_WIDTH(S_WIDTH), .REF_WIDTH(REF_WIDTH), .PHASE_WIDTH(PHASE_WIDTH),
    .ACC_WIDTH(ACC_WIDTH), .N_WIDTH(N_WIDTH)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_start(i_start),
    .i_n_periods(i_n_periods), .i_sample_valid(i_sample_valid),
    .i_sample(i_sample), .i_sin(i_sin), .i_cos(i_cos), .i_phase(i_phase),
    .o_i(o_i), .o_q(o_q), .o_valid(o_valid), .o_busy(o_busy), .o_ovf(o_ovf)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_valid && i_en) begin
      valid_cnt = valid_cnt + 1;
      valid_cyc = cyc;
      cap_i     = o_i;
      cap_q     = o_q;
      cap_ovf   = o_ovf;
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One clock: the phase advances only when the DUT actually consumed the sample.
  task automatic tick();
    logic consumed;
    @(posedge i_clk);
    consumed = i_en && i_sample_valid;
    cyc++;
    if (consumed && i_phase == '0) last_wrap_cyc = cyc;
    #1;
    if (consumed) i_phase = i_phase + 1'b1;
  endtask

  task automatic run(input int sample, input int sin_v, input int cos_v, input int n,
                     input int start_phase, input int stall_at, input int restart_at,
                     output int latency);
    int v0, s;
    v0          = valid_cnt;
    i_sample    = S_WIDTH'(sample);
    i_sin       = REF_WIDTH'(sin_v);
    i_cos       = REF_WIDTH'(cos_v);
    i_n_periods = N_WIDTH'(n);
    i_phase     = PHASE_WIDTH'(start_phase);
    i_start     = 1'b1;
    tick();
    s       = cyc;
    i_start = 1'b0;
    check("busy_after_start", o_busy, 1);
    for (int k = 1; k <= 40000 && valid_cnt == v0; k++) begin
      if (k == stall_at) i_en = 1'b0;
      if (k == stall_at + 10) i_en = 1'b1;
      i_start = (k == restart_at);
      tick();
    end
    i_start = 1'b0;
    i_en    = 1'b1;
    latency = (valid_cnt > v0) ? valid_cyc - s : -1;
    repeat (4) tick();
    check("valid_pulses", valid_cnt - v0, 1);
    check("busy_after_done", o_busy, 0);
  endtask

  initial begin
    i_en           = 1'b1;
    i_sample_valid = 1'b1;
    repeat (3) tick();
    check("rst_o_i", o_i, 0);
    check("rst_o_q", o_q, 0);
    check("rst_o_valid", o_valid, 0);
    check("rst_o_busy", o_busy, 0);
    check("rst_o_ovf", o_ovf, 0);
    i_rst = 1'b1;
    repeat (2) tick();

    // Basic I: 100*2047*8192 samples
    run(100, 2047, 0, 1, 8188, 0, 0, lat);
    check("basic_o_i", cap_i, 1676902400);
    check("basic_o_q", cap_q, 0);
    check("basic_ovf", cap_ovf, 0);
    check("basic_latency", lat, 8198);
    check("basic_wrap_to_valid", valid_cyc - last_wrap_cyc, 2);

    // Two periods overflow 32 bits
    run(100, 2047, 0, 2, 8188, 0, 0, lat);
`ifdef LOCKIN_DEMOD_SATURATE_EN
    check("sat_o_i", cap_i, 2147483647);
`else
    check("sat_o_i", cap_i, -941162496);
`endif
    check("sat_ovf", cap_ovf, 1);
    check("sat_latency", lat, 16390);

    // Quadrature sign, sticky flag must clear on the first sample
    run(-5, 0, 1000, 3, 8188, 0, 0, lat);
    check("quad_o_i", cap_i, 0);
    check("quad_o_q", cap_q, -122880000);
    check("quad_ovf", cap_ovf, 0);
    check("quad_held_o_q", o_q, -122880000);

    // Alignment: start mid-period, nothing accumulated before phase 0
    run(7, -3, 11, 1, 4000, 0, 0, lat);
    check("align_o_i", cap_i, -172032);
    check("align_o_q", cap_q, 630784);
    check("align_latency", lat, 12386);
    check("align_wrap_to_valid", valid_cyc - last_wrap_cyc, 2);

    // Stall 10 cycles mid-ACC and pulse i_start during ACC
    run(100, 2047, 0, 1, 8188, 100, 200, lat);
    check("stall_o_i", cap_i, 1676902400);
    check("stall_latency", lat, 8208);

    // Reset mid-ACC
    begin
      int v0;
      v0          = valid_cnt;
      i_n_periods = N_WIDTH'(1);
      i_phase     = PHASE_WIDTH'(8188);
      i_start     = 1'b1;
      tick();
      i_start = 1'b0;
      repeat (500) tick();
      check("pre_rst_busy", o_busy, 1);
      check("pre_rst_o_i", o_i, 1676902400);
      #2 i_rst = 1'b0;
      #1;
      check("async_rst_o_i", o_i, 0);
      check("async_rst_o_busy", o_busy, 0);
      check("async_rst_o_valid", o_valid, 0);
      repeat (3) tick();
      i_rst = 1'b1;
      repeat (20) tick();
      check("post_rst_busy", o_busy, 0);
      check("post_rst_no_valid", valid_cnt - v0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
